// File: rtl/mem_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
// Sizes match the team's 64x8 single-port Memory block.
package mem_fifo_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 2 ** ADDR_W;
    // Level counts RAM entries plus the in-flight read and the output register, so it can reach DEPTH+1.
    localparam int LEVEL_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_READ,
        MEM_WRITE
    } mem_op_e;

endpackage

// File: rtl/mem_fifo_out_reg.sv
// Output holding register of the FIFO: loads from the RAM read port or directly
// from the producer (bypass), and releases its entry on a pop.
module mem_fifo_out_reg
    import mem_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_mem,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              load_byp,
    input  logic [DATA_W-1:0] byp_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // Loads only happen while the register is empty, so they never race a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_mem) begin
            out_valid <= 1'b1;
            out_data  <= mem_dout;
        end else if (load_byp) begin
            out_valid <= 1'b1;
            out_data  <= byp_data;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Valid/ready FIFO built on the shared 64x8 single-port Memory, one RAM access per cycle.
// Define MEM_FIFO_BYPASS_EN to let a push into an empty FIFO skip the RAM.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_din,
    input  logic [DATA_W-1:0]  mem_dout
);

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [LEVEL_W-1:0] mem_count;
    logic               rd_pend;
    logic               fetch;
    logic               push;
    logic               pop;
    logic               bypass;
    logic               push_mem;
    mem_op_e            mem_op;

    // A prefetch into the empty output register outranks a push for the single RAM port.
    assign fetch    = (mem_count != '0) && !rd_pend && !out_valid;
    assign in_ready = !rst && (mem_count != LEVEL_W'(DEPTH)) && !fetch;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

`ifdef MEM_FIFO_BYPASS_EN
    assign bypass = push && (mem_count == '0) && !rd_pend && !out_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push_mem = push && !bypass;

    always_comb begin
        mem_op = MEM_IDLE;
        if (!rst) begin
            if (fetch) begin
                mem_op = MEM_READ;
            end else if (push_mem) begin
                mem_op = MEM_WRITE;
            end
        end
    end

    // Memory port is driven combinationally so the RAM acts at the same edge as the pointers.
    always_comb begin
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (mem_op)
            MEM_READ: begin
                mem_ren  = 1'b1;
                mem_addr = rd_ptr;
            end
            MEM_WRITE: begin
                mem_wen  = 1'b1;
                mem_addr = wr_ptr;
                mem_din  = in_data;
            end
            default: begin
                mem_ren = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= (mem_op == MEM_READ);
            case (mem_op)
                MEM_READ: begin
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                    mem_count <= mem_count - LEVEL_W'(1);
                end
                MEM_WRITE: begin
                    wr_ptr    <= wr_ptr + ADDR_W'(1);
                    mem_count <= mem_count + LEVEL_W'(1);
                end
                default: begin
                    mem_count <= mem_count;
                end
            endcase
        end
    end

    mem_fifo_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_mem  (rd_pend),
        .mem_dout  (mem_dout),
        .load_byp  (bypass),
        .byp_data  (in_data),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    assign level = mem_count + LEVEL_W'(rd_pend) + LEVEL_W'(out_valid);

endmodule
